// File: rtl/aes_pkg.sv
// AES byte-substitution, word rotation and round-constant helpers.
// Words carry byte 0 in bits [7:0].
package aes_pkg;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Byte 1 moves to byte 0, byte 0 wraps to byte 3.
  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[7:0], x[31:8]};
  endfunction

  function automatic logic [7:0] rcon(input int i);
    case (i)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_sched.sv
// Iterative AES key expansion (one word per cycle, one shared SubWord)
// with a registered round-key read port.
module aes_key_sched
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6,
  parameter int NW = 4 * (Nr + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [32*Nk-1:0]  key,
  output logic              busy,
  output logic              done,
  output logic              rk_avail,
  input  logic              rd_en,
  input  logic [3:0]        rd_round,
  output logic              rd_valid,
  output logic [127:0]      rd_rkey,
  output logic              rd_err
);

  localparam int IW = $clog2(NW);
  localparam logic [IW-1:0] NK_W = IW'(Nk);
  localparam logic [IW-1:0] LAST = IW'(NW - 1);

  typedef enum logic [1:0] {IDLE, EXPAND, AVAIL} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [31:0]     w [NW];

  logic            key_hs, rd_ok;
  logic [IW-1:0]   i_mod, i_div, rb;
  logic [31:0]     prev, old, sub_in, sub_out, nxt;

  assign key_ready = (state != EXPAND);
  assign key_hs    = key_valid & key_ready;
  assign rd_ok     = rd_en && (state == AVAIL) && (rd_round <= 4'(Nr));
  assign rb        = IW'({rd_round, 2'b00});

  always_comb begin
    i_mod   = idx % NK_W;
    i_div   = idx / NK_W;
    prev    = w[idx - IW'(1)];
    old     = w[idx - NK_W];
    sub_in  = (i_mod == '0) ? rot_word(prev) : prev;
    sub_out = sub_word(sub_in);
    if (i_mod == '0)
      nxt = old ^ sub_out ^ {24'h0, rcon(int'(i_div))};
    else if (Nk > 6 && i_mod == IW'(4))
      nxt = old ^ sub_out;
    else
      nxt = old ^ prev;
  end

  // Word store is never reset; rk_avail and the state gate every read.
  always_ff @(posedge clk) begin
    if (key_hs) begin
      for (int i = 0; i < Nk; i++) w[IW'(i)] <= key[32*i +: 32];
    end else if (state == EXPAND) begin
      w[idx] <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rk_avail <= 1'b0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_rkey  <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= rd_ok;
      rd_err   <= rd_en & ~rd_ok;
      // Reads sample the store before a same-cycle key write lands.
      if (rd_ok) rd_rkey <= {w[rb + IW'(3)], w[rb + IW'(2)], w[rb + IW'(1)], w[rb]};
      case (state)
        IDLE, AVAIL: begin
          if (key_hs) begin
            state    <= EXPAND;
            idx      <= NK_W;
            busy     <= 1'b1;
            rk_avail <= 1'b0;
          end
        end
        EXPAND: begin
          if (idx == LAST) begin
            state    <= AVAIL;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b1;
            rk_avail <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
